// File: rtl/tile_line_fetcher_if.sv
// Tile line fetcher bus: line request, shared RAM read port and pixel stream.
// The fetcher uses the master modport; the video/RAM side uses the slave modport.
interface tile_line_fetcher_if #(
    parameter int Bits = 16
);
    logic            lineStart;
    logic [7:0]      lineY;
    logic [Bits-1:0] ramAddress;
    logic [7:0]      ramData;
    logic            ramRead;
    logic            pixelValid;
    logic [3:0]      pixelColor;
    logic [1:0]      pixelPalette;
    logic            busy;
    logic            lineDone;

    modport master (
        input  lineStart, lineY, ramData,
        output ramAddress, ramRead, pixelValid, pixelColor, pixelPalette, busy, lineDone
    );

    modport slave (
        output lineStart, lineY, ramData,
        input  ramAddress, ramRead, pixelValid, pixelColor, pixelPalette, busy, lineDone
    );
endinterface

// File: rtl/tile_line_fetcher.sv
// Scanline tile renderer: walks the tile map, fetches 4bpp pattern rows with
// flip attributes and streams one colour index per clock, gapless across tiles.
module tile_line_fetcher #(
    parameter int Bits         = 16,
    parameter int MapBase      = 0,
    parameter int PatternBase  = 8192,
    parameter int TilesPerLine = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    tile_line_fetcher_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [5:0] LastCol = 6'(TilesPerLine - 1);

    state_t          state, state_nxt;
    logic            accept;
    logic            load;
    logic [2:0]      slot;
    logic [5:0]      col;
    logic [4:0]      row;
    logic [2:0]      fy;
    logic [7:0]      idx_p0;
    logic            flip_h_p0, flip_v_p0;
    logic [1:0]      pal_p0;
    logic [31:0]     word_p0;
    logic [31:0]     shift_p1;
    logic [1:0]      pal_p1;
    logic [3:0]      cnt_p1;
    logic            done_q;
    logic [2:0]      fy_eff;
    logic [2:0]      slot_m2;
    logic [1:0]      pat_off;
    logic [Bits-1:0] map_addr, pat_addr, addr;

    function automatic logic [31:0] reverse_nibbles(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = w[4*(7-i) +: 4];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.lineStart) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                load = (slot == 3'd7);
                if (slot == 3'd7 && col == LastCol) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (slot == 3'd7) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The slot counter keeps running through DRAIN so it times the last 8 pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot   <= '0;
            col    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && (slot == 3'd7);
            if (accept) begin
                slot <= '0;
                col  <= '0;
            end else if (state != IDLE) begin
                slot <= slot + 3'd1;
                if (load) col <= col + 6'd1;
            end
        end
    end

    // Stage p0: RAM capture (index, attributes, pattern row word)
    always_ff @(posedge clk) begin
        if (accept) begin
            row <= bus.lineY[7:3];
            fy  <= bus.lineY[2:0];
        end
        if (state == FETCH) begin
            case (slot)
                3'd0: idx_p0 <= bus.ramData;
                3'd1: begin
                    flip_h_p0 <= bus.ramData[7];
                    flip_v_p0 <= bus.ramData[6];
                    pal_p0    <= bus.ramData[1:0];
                end
                3'd2, 3'd3, 3'd4, 3'd5: word_p0 <= {word_p0[23:0], bus.ramData};
                default: ;
            endcase
        end
    end

    // Stage p1: pixel shift register, zero-filled so idle outputs read as 0
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_p1 <= '0;
            pal_p1   <= '0;
            cnt_p1   <= '0;
        end else if (load) begin
            shift_p1 <= flip_h_p0 ? reverse_nibbles(word_p0) : word_p0;
            pal_p1   <= pal_p0;
            cnt_p1   <= 4'd8;
        end else begin
            shift_p1 <= {shift_p1[27:0], 4'h0};
            if (cnt_p1 != 4'd0) cnt_p1 <= cnt_p1 - 4'd1;
            if (cnt_p1 == 4'd1) pal_p1 <= '0;
        end
    end

    // Outside slot cycles 2..5 the pattern offset sticks at 3 so the bus holds its last address.
    always_comb begin
        fy_eff   = flip_v_p0 ? ~fy : fy;
        slot_m2  = slot - 3'd2;
        pat_off  = (state == FETCH && slot >= 3'd2 && slot <= 3'd5) ? slot_m2[1:0] : 2'd3;
        map_addr = Bits'(MapBase) + Bits'({row, col, 1'b0}) + Bits'(slot[0]);
        pat_addr = Bits'(PatternBase) + Bits'({idx_p0, fy_eff, pat_off});
        if (state == IDLE)                      addr = '0;
        else if (state == FETCH && slot < 3'd2) addr = map_addr;
        else                                    addr = pat_addr;
    end

    assign bus.ramAddress   = addr;
    assign bus.ramRead      = (state != IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.pixelValid   = (cnt_p1 != 4'd0);
    assign bus.pixelColor   = shift_p1[31:28];
    assign bus.pixelPalette = pal_p1;
    assign bus.lineDone     = done_q;
endmodule

// File: tb/tb_tile_line_fetcher.sv
// Scoreboard bench for tile_line_fetcher: three instances (N=1, 2, 32) share one RAM model.
module tb_tile_line_fetcher;
    typedef struct {
        int         cyc;
        logic [1:0] pal;
        logic [3:0] col;
    } exp_t;

    logic clk = 1'b0;
    logic rst, rst_c;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] mem [0:65535];
    exp_t       q  [3][$];
    int         dq [3][$];

    logic        ls [3];
    logic [7:0]  ly [3];
    logic        pv [3];
    logic [3:0]  pc [3];
    logic [1:0]  pp [3];
    logic        ld [3];
    logic        rr [3];
    logic        bz [3];
    logic [15:0] ad [3];

    logic [3:0] exp_t1   [8] = '{4'h0, 4'he, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0};
    logic [3:0] exp_flip [8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] exp_walk [16] = '{4'h0, 4'hf, 4'h1, 4'he, 4'h2, 4'hd, 4'h3, 4'hc,
                                  4'ha, 4'h1, 4'hb, 4'h2, 4'hc, 4'h3, 4'hd, 4'h4};
    int         exp_addr [9] = '{'h0B80, 'h0B81, 'h2844, 'h2845, 'h2846, 'h2847,
                                 'h2847, 'h2847, 'h0B82};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tile_line_fetcher_if #(.Bits(16)) ifa ();
    tile_line_fetcher_if #(.Bits(16)) ifb ();
    tile_line_fetcher_if #(.Bits(16)) ifc ();

    tile_line_fetcher #(.TilesPerLine(1))  dut_a (.clk(clk), .reset(rst),   .bus(ifa));
    tile_line_fetcher #(.TilesPerLine(2))  dut_b (.clk(clk), .reset(rst),   .bus(ifb));
    tile_line_fetcher #(.TilesPerLine(32)) dut_c (.clk(clk), .reset(rst_c), .bus(ifc));

    assign ifa.ramData = mem[ifa.ramAddress];
    assign ifb.ramData = mem[ifb.ramAddress];
    assign ifc.ramData = mem[ifc.ramAddress];
    assign ifa.lineStart = ls[0]; assign ifa.lineY = ly[0];
    assign ifb.lineStart = ls[1]; assign ifb.lineY = ly[1];
    assign ifc.lineStart = ls[2]; assign ifc.lineY = ly[2];

    assign pv[0] = ifa.pixelValid;   assign pv[1] = ifb.pixelValid;   assign pv[2] = ifc.pixelValid;
    assign pc[0] = ifa.pixelColor;   assign pc[1] = ifb.pixelColor;   assign pc[2] = ifc.pixelColor;
    assign pp[0] = ifa.pixelPalette; assign pp[1] = ifb.pixelPalette; assign pp[2] = ifc.pixelPalette;
    assign ld[0] = ifa.lineDone;     assign ld[1] = ifb.lineDone;     assign ld[2] = ifc.lineDone;
    assign rr[0] = ifa.ramRead;      assign rr[1] = ifb.ramRead;      assign rr[2] = ifc.ramRead;
    assign bz[0] = ifa.busy;         assign bz[1] = ifb.busy;         assign bz[2] = ifc.busy;
    assign ad[0] = ifa.ramAddress;   assign ad[1] = ifb.ramAddress;   assign ad[2] = ifc.ramAddress;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cyc %0d", nm, act, act, req, req, cyc);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s at cyc %0d", nm, cyc);
    endtask

    // Monitor: every valid pixel and every lineDone pulse is matched against the queues.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (pv[k]) begin
                if (q[k].size() == 0) begin
                    flag($sformatf("pix_unexpected_%0d col=%0h", k, pc[k]));
                end else begin
                    e = q[k].pop_front();
                    chk($sformatf("pix_color_%0d", k), int'(pc[k]), int'(e.col));
                    chk($sformatf("pix_pal_%0d", k), int'(pp[k]), int'(e.pal));
                    chk($sformatf("pix_cycle_%0d", k), cyc, e.cyc);
                end
            end else begin
                chk($sformatf("idle_pix_zero_%0d", k), int'({pc[k], pp[k]}), 0);
            end
            if (ld[k]) begin
                if (dq[k].size() == 0) flag($sformatf("done_unexpected_%0d", k));
                else chk($sformatf("done_cycle_%0d", k), cyc, dq[k].pop_front());
            end
        end
    end

    task automatic push(input int k, input int cy, input logic [1:0] pal, input logic [3:0] c);
        exp_t e;
        e.cyc = cy;
        e.pal = pal;
        e.col = c;
        q[k].push_back(e);
    endtask

    // Full-line pattern: tile c row 2 byte b holds c*4+b, palette c%4.
    task automatic push_full(input int t0, input int count);
        logic [7:0] v;
        int         c, p;
        for (int i = 0; i < count; i++) begin
            c = i / 8;
            p = i % 8;
            v = 8'(c * 4 + p / 2);
            push(2, t0 + 8 + i, 2'(c % 4), (p % 2 == 0) ? v[7:4] : v[3:0]);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after the accepting edge.
    task automatic start(input int k, input logic [7:0] y, output int t0);
        ls[k] = 1'b1;
        ly[k] = y;
        @(negedge clk);
        t0 = cyc;
        ls[k] = 1'b0;
    endtask

    task automatic run_line(input int k, input int poke, output int nrr, output int npv,
                            output int first, output int last);
        bit seen;
        seen = 1'b0;
        nrr = 0; npv = 0; first = -1; last = -1;
        for (int i = 0; i < 700 && !seen; i++) begin
            ls[k] = (i == poke);
            if (rr[k]) nrr++;
            if (pv[k]) begin
                npv++;
                if (first < 0) first = i;
                last = i;
            end
            if (ld[k]) seen = 1'b1;
            else @(negedge clk);
        end
        ls[k] = 1'b0;
        if (!seen) flag($sformatf("line_timeout_%0d", k));
    endtask

    initial begin
        int t0, nrr, npv, f, l;
        rst = 1'b1; rst_c = 1'b1;
        for (int k = 0; k < 3; k++) begin ls[k] = 1'b0; ly[k] = 8'h00; end
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ramRead_%0d", k), int'(rr[k]), 0);
            chk($sformatf("rst_busy_%0d", k), int'(bz[k]), 0);
            chk($sformatf("rst_valid_%0d", k), int'(pv[k]), 0);
            chk($sformatf("rst_addr_%0d", k), int'(ad[k]), 0);
            chk($sformatf("rst_done_%0d", k), int'(ld[k]), 0);
        end

        // Tile 0 row 0, no flips
        mem[0] = 8'h00; mem[1] = 8'h00;
        mem[8192] = 8'h0e; mem[8193] = 8'h80; mem[8194] = 8'h88; mem[8195] = 8'h00;
        start(0, 8'h00, t0);
        for (int i = 0; i < 8; i++) push(0, t0 + 8 + i, 2'd0, exp_t1[i]);
        dq[0].push_back(t0 + 16);
        run_line(0, -1, nrr, npv, f, l);
        chk("t1_busy_at_done", int'(bz[0]), 0);
        chk("t1_ramread_cycles", nrr, 16);

        // Flip H and V, palette 3, restarted on the lineDone cycle
        mem[1] = 8'hC3;
        mem[8220] = 8'h12; mem[8221] = 8'h34; mem[8222] = 8'h56; mem[8223] = 8'h78;
        start(0, 8'h00, t0);
        for (int i = 0; i < 8; i++) push(0, t0 + 8 + i, 2'd3, exp_flip[i]);
        dq[0].push_back(t0 + 16);
        run_line(0, -1, nrr, npv, f, l);
        chk("flip_pixels", npv, 8);

        // Address walk, N=2, lineY=0xB9
        mem[16'h0B80] = 8'h42; mem[16'h0B81] = 8'h00;
        mem[16'h0B82] = 8'h00; mem[16'h0B83] = 8'h02;
        mem[16'h2844] = 8'h0F; mem[16'h2845] = 8'h1E; mem[16'h2846] = 8'h2D; mem[16'h2847] = 8'h3C;
        mem[8196] = 8'hA1; mem[8197] = 8'hB2; mem[8198] = 8'hC3; mem[8199] = 8'hD4;
        @(negedge clk);
        start(1, 8'hB9, t0);
        for (int i = 0; i < 16; i++) push(1, t0 + 8 + i, (i < 8) ? 2'd0 : 2'd2, exp_walk[i]);
        dq[1].push_back(t0 + 24);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("walk_addr_%0d", i), int'(ad[1]), exp_addr[i]);
            @(negedge clk);
        end
        run_line(1, -1, nrr, npv, f, l);

        // Full line N=32 with an ignored mid-line lineStart, then back-to-back line
        for (int c = 0; c < 32; c++) begin
            mem[128 + 2*c] = 8'(c);
            mem[129 + 2*c] = 8'(c % 4);
            for (int b = 0; b < 4; b++) mem[8192 + c*32 + 8 + b] = 8'(c * 4 + b);
        end
        @(negedge clk);
        start(2, 8'h0A, t0);
        push_full(t0, 256);
        dq[2].push_back(t0 + 264);
        run_line(2, 50, nrr, npv, f, l);
        chk("full_ramread_cycles", nrr, 264);
        chk("full_valid_cycles", npv, 256);
        chk("full_valid_contiguous", l - f + 1, 256);
        chk("full_first_pixel_offset", f, 8);
        start(2, 8'h0A, t0);
        push_full(t0, 256);
        dq[2].push_back(t0 + 264);
        run_line(2, -1, nrr, npv, f, l);
        chk("b2b_valid_cycles", npv, 256);
        chk("b2b_ramread_cycles", nrr, 264);

        // Reset during pixel 100, then a clean restart
        start(2, 8'h0A, t0);
        push_full(t0, 101);
        repeat (108) @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        chk("rst_mid_valid", int'(pv[2]), 0);
        chk("rst_mid_color", int'(pc[2]), 0);
        chk("rst_mid_pal", int'(pp[2]), 0);
        chk("rst_mid_busy", int'(bz[2]), 0);
        chk("rst_mid_ramread", int'(rr[2]), 0);
        chk("rst_mid_addr", int'(ad[2]), 0);
        chk("rst_mid_done", int'(ld[2]), 0);
        @(negedge clk);
        start(2, 8'h0A, t0);
        push_full(t0, 256);
        dq[2].push_back(t0 + 264);
        run_line(2, -1, nrr, npv, f, l);
        chk("restart_valid_cycles", npv, 256);
        chk("restart_first_pixel_offset", f, 8);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pix_queue_drained_%0d", k), q[k].size(), 0);
            chk($sformatf("done_queue_drained_%0d", k), dq[k].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tile_line_fetcher.md
# tile_line_fetcher

Tile-plane line renderer sitting directly downstream of the shared 64 KB `Ram`. Once per scanline it walks the tile map, fetches each tile's 4bpp pattern row, applies the flip attributes and streams one colour index plus palette id per clock to the video output stage. While a line is in progress it owns the RAM address bus; the bus arbiter selects `ramAddress` whenever `ramRead` is high.

## Interface
- `Bits`, 16: RAM address width.
- `MapBase`, 0: tile-map base address. Map is 64 entries per row, 2 bytes per entry: byte 0 is the tile index; byte 1 is {flipH, flipV, 4'b0, palette[1:0]}.
- `PatternBase`, 8192: pattern base address. 32 bytes per tile, 4 bytes per pixel row, high nibble is the left pixel.
- `TilesPerLine`, 32: tiles rendered per line (1..64).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `lineStart` in 1: one-cycle request to render a line.
- `lineY` in 8: scanline number, sampled with `lineStart`.
- `ramAddress` out Bits: RAM read address.
- `ramData` in 8: RAM `dataOut`, combinational from `ramAddress` within the same cycle.
- `ramRead` out 1: fetcher owns the RAM bus.
- `pixelValid` out 1: pixel outputs are valid this cycle.
- `pixelColor` out 4: colour index.
- `pixelPalette` out 2: palette id.
- `busy` out 1: a line is in progress.
- `lineDone` out 1: one-cycle pulse at the end of a line.

## Operation
- States:
  - IDLE → FETCH on `lineStart`.
  - FETCH → DRAIN after the last tile slot.
  - DRAIN → IDLE after 8 cycles, with `lineDone` pulsed on entry to IDLE.
- On accept, latch the tile row `lineY[7:3]` and the fine row `fy = lineY[2:0]`, and clear the column counter `col`.
- FETCH runs one 8-cycle slot per tile. Slot cycle `s` drives `ramAddress` and samples `ramData` at the end of the cycle:
  - s=0: `MapBase + row*128 + col*2`. Latch the tile index.
  - s=1: the same address + 1. Latch the attributes.
  - s=2..5: `PatternBase + index*32 + fy'*4 + (s-2)`, where `fy' = flipV ? 7-fy : fy`. Collect the 4 bytes into a 32-bit word.
  - s=6,7: no fetch. `ramAddress` holds its last value.
- At the end of s=7, load the 32-bit word and the palette into the pixel shift register, then increment `col`.
  - flipH=0: pixel order is the nibbles of byte0-hi, byte0-lo, …, byte3-lo.
  - flipH=1: the exact reverse order.
- The shift register emits one nibble per cycle for 8 cycles, concurrently with the next slot's fetch. Rendering is gapless.
- Address arithmetic is modulo 2^Bits. Tile index × 32 is a 13-bit offset.
- `ramRead` = `busy` = 1 in FETCH and DRAIN. In IDLE both are 0 and `ramAddress` is 0.
- `lineStart` while busy is ignored.
- `lineStart` in the same cycle as `lineDone` is accepted.
- `reset` at any time returns the block to IDLE:
  - All outputs 0, shift register cleared, no `lineDone`.
  - The next line starts cleanly.

## Timing
- Reset value of every output is 0.
- `lineStart` sampled at edge T:
  - Slot 0 occupies cycles T+1..T+8.
  - Pixel 0 is valid at T+9.
  - The last pixel is at T+8+8N, where N = `TilesPerLine`.
- `pixelValid` is high for exactly 8N consecutive cycles.
- `lineDone` and `busy`=0 occur at T+9+8N.
- Pixel outputs are registered, straight from the shift register. They hold 0 when `pixelValid` is low.
- RAM data is consumed in the same cycle the address is driven. There is no read latency.

## Test plan
- Tile 0 row 0 test:
  - Preload: map[0]=0x00, map[1]=0x00; pattern bytes 8192..8195 = 0e 80 88 00; N=1.
  - Stimulus: `lineStart` with `lineY`=0.
  - Required: pixels 0,e,8,0,8,8,0,0 at T+9..T+16, palette 0; `lineDone` at T+17.
- Flip H and V:
  - Preload: attribute byte 0xC3; pattern row 7 bytes = 12 34 56 78; N=1.
  - Stimulus: `lineY`=0.
  - Required: pixels 8,7,6,5,4,3,2,1, palette 3.
- Address walk:
  - Stimulus: `lineY`=0xB9, N=2; map index at 0x0B80 = 0x42.
  - Required:
    - Slot 0 addresses 0x0B80, 0x0B81.
    - Pattern addresses 0x2000+0x42*32+4+{0..3} = 0x2844..0x2847.
    - Slot 1 starts at 0x0B82.
- Full line:
  - Stimulus: N=32.
  - Required: 256 contiguous `pixelValid` cycles; `ramRead` high for 264 cycles; `lineStart` pulsed mid-line is ignored; back-to-back `lineStart` on the `lineDone` cycle starts a new line.
- Reset mid-line:
  - Stimulus: assert `reset` at pixel 100.
  - Required: next cycle all outputs are 0 and the block is IDLE; a following `lineStart` gives correct first pixels.
